// File: rtl/datapath_gen_if.sv
// Bus interface for datapath_gen: groups the control, data and status
// signals so the datapath and its driver share one bundle. clk and rst_n
// stay outside as plain ports on the datapath itself.
interface datapath_gen_if #(
  parameter int WIDTH = 16,
  parameter int REGS  = 8,
  parameter int IMM_W = 5
);
  localparam int AW = $clog2(REGS);

  logic [WIDTH-1:0] datapath_in;
  logic             wb_sel;
  logic [AW-1:0]    w_addr;
  logic             w_en;
  logic [AW-1:0]    r_addr;
  logic             en_A;
  logic             en_B;
  logic             en_C;
  logic             en_status;
  logic [1:0]       shift_op;
  logic             sel_A;
  logic             sel_B;
  logic [1:0]       ALU_op;
  logic             mul_start;
  logic             busy;
  logic             mul_done;
  logic [WIDTH-1:0] datapath_out;
  logic             Z_out;
  logic             N_out;
  logic             V_out;

  // Controller side: drives data and control, observes results
  modport master (
    output datapath_in, wb_sel, w_addr, w_en, r_addr,
           en_A, en_B, en_C, en_status, shift_op, sel_A, sel_B,
           ALU_op, mul_start,
    input  busy, mul_done, datapath_out, Z_out, N_out, V_out
  );

  // Datapath side
  modport slave (
    input  datapath_in, wb_sel, w_addr, w_en, r_addr,
           en_A, en_B, en_C, en_status, shift_op, sel_A, sel_B,
           ALU_op, mul_start,
    output busy, mul_done, datapath_out, Z_out, N_out, V_out
  );
endinterface

// File: rtl/datapath_gen.sv
// datapath_gen: register file, A/B operand registers, B-path shifter,
// 4-function ALU, C result register and Z/N/V status flags.
// Optional macro DATAPATH_GEN_MUL_EN adds an unsigned shift-add multiplier
// (one iteration per clock, WIDTH iterations) that writes C and the flags on
// completion. Without the macro, busy/mul_done are tied low and mul_start is
// ignored.
module datapath_gen #(
  parameter int WIDTH = 16,
  parameter int REGS  = 8,
  parameter int IMM_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  datapath_gen_if.slave bus
);
  localparam int AW = $clog2(REGS);

  logic [WIDTH-1:0] r_regs [REGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  logic [WIDTH-1:0] w_rData;
  logic [WIDTH-1:0] w_wData;
  logic [WIDTH-1:0] w_shB;
  logic [WIDTH-1:0] w_valA;
  logic [WIDTH-1:0] w_valB;
  logic [WIDTH-1:0] w_alu;
  logic             w_z;
  logic             w_n;
  logic             w_v;

  // Read is asynchronous; a same-edge write is only seen on the next cycle
  assign w_rData = r_regs[bus.r_addr];
  assign w_wData = bus.wb_sel ? bus.datapath_in : r_c;

  // Register file storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
    end else if (bus.w_en) begin
      r_regs[bus.w_addr] <= w_wData;
    end
  end

  // Operand registers A and B load independently from the read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (bus.en_A) r_a <= w_rData;
      if (bus.en_B) r_b <= w_rData;
    end
  end

  // B-path shifter, operand muxes, ALU and its flags
  always_comb begin
    w_shB = r_b;
    case (bus.shift_op)
      2'b01:   w_shB = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_shB = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_shB = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_shB = r_b;
    endcase

    w_valA = bus.sel_A ? '0 : r_a;
    w_valB = bus.sel_B ? WIDTH'(bus.datapath_in[IMM_W-1:0]) : w_shB;

    w_alu = '0;
    w_v   = 1'b0;
    case (bus.ALU_op)
      2'b00: begin
        w_alu = w_valA + w_valB;
        w_v   = (w_valA[WIDTH-1] == w_valB[WIDTH-1]) &&
                (w_alu[WIDTH-1] != w_valA[WIDTH-1]);
      end
      2'b01: begin
        w_alu = w_valA - w_valB;
        w_v   = (w_valA[WIDTH-1] != w_valB[WIDTH-1]) &&
                (w_alu[WIDTH-1] != w_valA[WIDTH-1]);
      end
      2'b10:   w_alu = w_valA & w_valB;
      default: w_alu = ~w_valB;
    endcase

    w_z = (w_alu == '0);
    w_n = w_alu[WIDTH-1];
  end

`ifdef DATAPATH_GEN_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} mulState_t;

  mulState_t          r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] w_prodNext;

  // Partial product after the current shift-add iteration
  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Multiplier FSM; also owns C and the flags since both the ALU and the
  // multiplier completion write them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en_C) r_c <= w_alu;
          if (bus.en_status) begin
            r_z <= w_z;
            r_n <= w_n;
            r_v <= w_v;
          end
          if (bus.mul_start) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_mcand  <= {{WIDTH{1'b0}}, w_valA};
            r_mplier <= w_valB;
            r_prod   <= '0;
            r_cnt    <= CW'(WIDTH);
          end
        end
        RUN: begin
          r_prod   <= w_prodNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_c     <= w_prodNext[WIDTH-1:0];
            r_z     <= (w_prodNext[WIDTH-1:0] == '0);
            r_n     <= w_prodNext[WIDTH-1];
            r_v     <= (w_prodNext[2*WIDTH-1:WIDTH] != '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.mul_done = r_done;
`else
  // Result register and status flags load independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else begin
      if (bus.en_C) r_c <= w_alu;
      if (bus.en_status) begin
        r_z <= w_z;
        r_n <= w_n;
        r_v <= w_v;
      end
    end
  end

  assign bus.busy     = 1'b0;
  assign bus.mul_done = 1'b0;
`endif

  assign bus.datapath_out = r_c;
  assign bus.Z_out        = r_z;
  assign bus.N_out        = r_n;
  assign bus.V_out        = r_v;
endmodule
